// File: rtl/bus_router.sv
// bus_router: routes one master request to one of SLAVES address windows and
// tracks that single transaction until its slave answers, times out, or the
// address turns out to be unmapped.
`timescale 1ns/1ps

// Per-slot window compare: BASE <= addr < TOP, unsigned.
module bus_router_win #(
  parameter logic [31:0] BASE = 32'h0,
  parameter logic [31:0] TOP  = 32'h0
) (
  input  logic [31:0] addr_i,
  output logic        hit_o
);
  // Offset form keeps the compare valid for BASE == 0; an empty or inverted
  // window never hits.
  localparam logic [31:0] SIZE = TOP - BASE;
  localparam bit          NONEMPTY = (TOP > BASE);
  assign hit_o = NONEMPTY && ((addr_i - BASE) < SIZE);
endmodule

module bus_router #(
  parameter int SLAVES  = 4,
  parameter int TIMEOUT = 255,
  parameter logic [SLAVES*32-1:0] BASE_ADDR =
    {32'h0200_0000, 32'h0100_0000, 32'h0010_0000, 32'h0000_0000},
  parameter logic [SLAVES*32-1:0] TOP_ADDR =
    {32'h0201_0000, 32'h0100_1000, 32'h0020_0000, 32'h0000_1000}
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   memory_valid,
  input  logic                   memory_instr,
  input  logic [31:0]            memory_addr,
  input  logic [31:0]            memory_wdata,
  input  logic [3:0]             memory_wstrb,
  output logic [31:0]            memory_rdata,
  output logic                   memory_ready,
  output logic                   memory_error,
  output logic [SLAVES-1:0]      slave_valid,
  output logic                   slave_instr,
  output logic [31:0]            slave_addr,
  output logic [31:0]            slave_wdata,
  output logic [3:0]             slave_wstrb,
  input  logic [SLAVES*32-1:0]   slave_rdata,
  input  logic [SLAVES-1:0]      slave_ready
);
  localparam int SEL_W = (SLAVES > 1) ? $clog2(SLAVES) : 1;
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_ERR  = 2'd2;

  logic [SLAVES-1:0]        win_hit;
  logic [SLAVES-1:0][31:0]  rdata_a;
  logic                     hit;
  logic [SEL_W-1:0]         hit_idx;
  logic [31:0]              base_sel;

  logic [1:0]               state_q, state_d;
  logic [SEL_W-1:0]         sel_q, sel_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d, cnt_inc;

  logic [SLAVES-1:0]        sv_c;
  logic                     rdy_c, err_c;
  logic [31:0]              rdata_c;

  assign rdata_a = slave_rdata;
  assign cnt_inc = cnt_q + CNT_W'(1);

  for (genvar g = 0; g < SLAVES; g++) begin : g_win
    bus_router_win #(
      .BASE (BASE_ADDR[32*g +: 32]),
      .TOP  (TOP_ADDR[32*g +: 32])
    ) u_win (
      .addr_i (memory_addr),
      .hit_o  (win_hit[g])
    );
  end

  // Priority pick: scanning downward lets the lowest hitting index win.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    base_sel = 32'h0;
    for (int i = SLAVES - 1; i >= 0; i--) begin
      if (win_hit[i]) begin
        hit      = 1'b1;
        hit_idx  = SEL_W'(i);
        base_sel = BASE_ADDR[32*i +: 32];
      end
    end
  end

  // Transaction FSM and response mux. The counter holds cycles already spent
  // in BUSY, so its incremented value reaching TIMEOUT puts the error
  // exactly TIMEOUT cycles after the request cycle. Ready beats timeout.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    sv_c    = '0;
    rdy_c   = 1'b0;
    err_c   = 1'b0;
    rdata_c = 32'h0;
    case (state_q)
      S_IDLE: begin
        if (memory_valid) begin
          if (hit) begin
            sv_c[hit_idx] = 1'b1;
            sel_d         = hit_idx;
            if (slave_ready[hit_idx]) begin
              rdy_c   = 1'b1;
              rdata_c = rdata_a[hit_idx];
            end else begin
              state_d = S_BUSY;
              cnt_d   = '0;
            end
          end else begin
            state_d = S_ERR;
          end
        end
      end
      S_BUSY: begin
        cnt_d = cnt_inc;
        if (slave_ready[sel_q]) begin
          rdy_c   = 1'b1;
          rdata_c = rdata_a[sel_q];
          state_d = S_IDLE;
        end else if ((TIMEOUT != 0) && (cnt_inc == CNT_W'(TIMEOUT))) begin
          rdy_c   = 1'b1;
          err_c   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_ERR: begin
        rdy_c   = 1'b1;
        err_c   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset abandons any transaction in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
    end
  end

  assign slave_valid  = reset ? '0 : sv_c;
  assign memory_ready = !reset && rdy_c;
  assign memory_error = !reset && err_c;
  assign memory_rdata = reset ? 32'h0 : rdata_c;
  assign slave_instr  = memory_instr;
  assign slave_addr   = memory_addr - base_sel;
  assign slave_wdata  = memory_wdata;
  assign slave_wstrb  = memory_wstrb;
endmodule

// File: tb/tb_bus_router.sv
// tb_bus_router: randomized + directed stimulus; expected responses are queued
// with their due cycle and checked by an independent monitor.
`timescale 1ns/1ps

module tb_bus_router;
  localparam int TO = 8;

  logic              clock, reset;
  logic              memory_valid, memory_instr;
  logic [31:0]       memory_addr, memory_wdata;
  logic [3:0]        memory_wstrb;
  logic [31:0]       memory_rdata;
  logic              memory_ready, memory_error;
  logic [3:0]        slave_valid;
  logic              slave_instr;
  logic [31:0]       slave_addr, slave_wdata;
  logic [3:0]        slave_wstrb;
  logic [3:0][31:0]  srd;
  logic [3:0]        slave_ready;

  bus_router #(.SLAVES(4), .TIMEOUT(TO)) dut (
    .clock        (clock),
    .reset        (reset),
    .memory_valid (memory_valid),
    .memory_instr (memory_instr),
    .memory_addr  (memory_addr),
    .memory_wdata (memory_wdata),
    .memory_wstrb (memory_wstrb),
    .memory_rdata (memory_rdata),
    .memory_ready (memory_ready),
    .memory_error (memory_error),
    .slave_valid  (slave_valid),
    .slave_instr  (slave_instr),
    .slave_addr   (slave_addr),
    .slave_wdata  (slave_wdata),
    .slave_wstrb  (slave_wstrb),
    .slave_rdata  (srd),
    .slave_ready  (slave_ready)
  );

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  logic [31:0] BASE [4] = '{32'h0000_0000, 32'h0010_0000, 32'h0100_0000, 32'h0200_0000};
  logic [31:0] TOP  [4] = '{32'h0000_1000, 32'h0020_0000, 32'h0100_1000, 32'h0201_0000};

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  function automatic int ref_slot(input logic [31:0] a);
    for (int i = 0; i < 4; i++)
      if (a >= BASE[i] && a < TOP[i]) return i;
    return -1;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [31:0] rd, input logic err, input int c);
    exp_t e;
    e.rd = rd; e.err = err; e.cyc = c;
    q.push_back(e);
  endtask

  // One master transaction plus the slave behaviour: slot answers lat cycles
  // after the request (0 = same cycle). Optionally drive a dropped request and
  // a stray ready from another slot while the transaction is pending.
  task automatic req(input logic [31:0] a, input logic [3:0] ws, input logic [31:0] wd,
                     input int lat, input logic [31:0] rd, input bit viol, input bit spur);
    int s;
    s = ref_slot(a);
    memory_valid = 1'b1;
    memory_addr  = a;
    memory_wstrb = ws;
    memory_wdata = wd;
    memory_instr = 1'($urandom);
    for (int j = 0; j < 4; j++) srd[j] = $urandom;
    #1;
    if (s < 0) begin
      chk("unmapped_valid", 32'(slave_valid), 32'h0);
      chk("unmapped_addr", slave_addr, a);
      push(32'h0, 1'b1, cyc + 1);
      tick();
      memory_valid = 1'b0;
      #1 chk("unmapped_valid_err", 32'(slave_valid), 32'h0);
      tick();
    end else begin
      chk("slave_valid", 32'(slave_valid), 32'(1) << s);
      chk("slave_addr", slave_addr, a - BASE[s]);
      chk("slave_wstrb", 32'(slave_wstrb), 32'(ws));
      chk("slave_wdata", slave_wdata, wd);
      chk("slave_instr", 32'(slave_instr), 32'(memory_instr));
      if (lat == 0) begin
        srd[s] = rd;
        slave_ready[s] = 1'b1;
        push(rd, 1'b0, cyc);
        tick();
        slave_ready  = '0;
        memory_valid = 1'b0;
      end else begin
        if (lat > TO) push(32'h0, 1'b1, cyc + TO);
        else          push(rd, 1'b0, cyc + lat);
        for (int k = 1; k <= lat; k++) begin
          tick();
          memory_valid = 1'b0;
          slave_ready  = '0;
          for (int j = 0; j < 4; j++) srd[j] = $urandom;
          if (k == 1 && viol && lat >= 2) begin
            memory_valid = 1'b1;
            memory_addr  = BASE[(s + 2) % 4] + 32'h10;
            #1 chk("dropped_req_valid", 32'(slave_valid), 32'h0);
          end
          if (k == 1 && spur && lat >= 2) slave_ready[(s + 1) % 4] = 1'b1;
          if (k == lat) begin
            srd[s] = rd;
            slave_ready[s] = 1'b1;
          end
        end
        tick();
        slave_ready  = '0;
        memory_valid = 1'b0;
      end
    end
  endtask

  // Monitor: every completion must match the head of the queue in cycle and
  // content; nothing may complete unexpectedly; outputs idle at zero.
  always @(negedge clock) begin
    exp_t e;
    if (reset) begin
      chk("rst_ready", 32'(memory_ready), 32'h0);
      chk("rst_error", 32'(memory_error), 32'h0);
      chk("rst_rdata", memory_rdata, 32'h0);
      chk("rst_slave_valid", 32'(slave_valid), 32'h0);
    end else begin
      while (q.size() > 0 && q[0].cyc < cyc) begin
        chk("ready_missing_cycle", 32'(cyc), 32'(q[0].cyc));
        void'(q.pop_front());
      end
      if (memory_ready) begin
        if (q.size() == 0) begin
          chk("spurious_ready", 32'(memory_ready), 32'h0);
        end else begin
          e = q.pop_front();
          chk("ready_cycle", 32'(cyc), 32'(e.cyc));
          chk("rdata", memory_rdata, e.rd);
          chk("error", 32'(memory_error), 32'(e.err));
        end
      end else begin
        chk("idle_error", 32'(memory_error), 32'h0);
        chk("idle_rdata", memory_rdata, 32'h0);
      end
    end
  end

  initial begin
    int          pick;
    logic [31:0] a;
    reset = 1'b1;
    memory_valid = 1'b0; memory_instr = 1'b0;
    memory_addr = 32'h0; memory_wdata = 32'h0; memory_wstrb = 4'h0;
    srd = '0; slave_ready = '0;
    tick(); tick();
    reset = 1'b0;
    tick();

    // Test-plan directed cases
    req(32'h0010_0040, 4'h0, 32'h0, 1, 32'hDEAD_BEEF, 1'b0, 1'b0);
    req(32'h0100_0000, 4'hF, 32'h0000_0001, 4, 32'h1234_5678, 1'b0, 1'b1);
    req(32'h0300_0000, 4'h0, 32'h0, 0, 32'h0, 1'b0, 1'b0);
    req(32'h0200_0010, 4'h0, 32'h0, 10, 32'hCAFE_F00D, 1'b0, 1'b0);

    // Reset mid-transaction on slot 1; the late ready must vanish.
    memory_valid = 1'b1; memory_addr = 32'h0010_0100; memory_wstrb = 4'h0;
    #1 chk("rst_pre_valid", 32'(slave_valid), 32'h2);
    tick();
    memory_valid = 1'b0;
    tick();
    reset = 1'b1;
    memory_valid = 1'b1; memory_addr = 32'h0000_0020;
    slave_ready = 4'hF;
    #1;
    chk("rst_busy_valid", 32'(slave_valid), 32'h0);
    chk("rst_busy_ready", 32'(memory_ready), 32'h0);
    chk("rst_busy_rdata", memory_rdata, 32'h0);
    tick();
    reset = 1'b0; memory_valid = 1'b0; slave_ready = '0;
    tick();
    slave_ready[1] = 1'b1;
    tick();
    slave_ready = '0;
    req(32'h0000_0040, 4'h0, 32'h0, 2, 32'hA5A5_0001, 1'b0, 1'b0);

    // Zero-wait back-to-back on slot 0
    for (int i = 0; i < 4; i++)
      req(32'(i * 4), 4'h0, 32'h0, 0, 32'h100 + 32'(i), 1'b0, 1'b0);

    // Window edges and timeout edges
    req(32'h0000_0FFC, 4'h3, 32'h55, 0, 32'h0BAD_0001, 1'b0, 1'b0);
    req(32'h0000_1000, 4'h0, 32'h0, 0, 32'h0, 1'b0, 1'b0);
    req(32'h001F_FFFC, 4'h0, 32'h0, 2, 32'h0BAD_0002, 1'b0, 1'b0);
    req(32'h0020_0000, 4'h0, 32'h0, 0, 32'h0, 1'b0, 1'b0);
    req(32'h0200_FFFF, 4'h0, 32'h0, TO, 32'h0BAD_0003, 1'b0, 1'b0);
    req(32'h0200_0000, 4'h0, 32'h0, TO - 1, 32'h0BAD_0004, 1'b0, 1'b0);
    req(32'h0201_0000, 4'h0, 32'h0, 0, 32'h0, 1'b0, 1'b0);
    req(32'h0010_0000, 4'h1, 32'h77, 3, 32'h0BAD_0005, 1'b1, 1'b1);

    // Randomized traffic
    for (int n = 0; n < 60; n++) begin
      pick = $urandom_range(0, 4);
      if (pick == 4) a = 32'h0300_0000 + 32'($urandom_range(0, 32'h0FFF_FFFF));
      else           a = BASE[pick] + ($urandom % (TOP[pick] - BASE[pick]));
      req(a, 4'($urandom), $urandom, $urandom_range(0, 10), $urandom,
          1'($urandom), 1'($urandom));
    end

    tick(); tick(); tick();
    chk("queue_drained", 32'(q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bus_router.md
# bus_router

Parametrised single-master, N-slave memory router between the arbiter's shared `memory_*` port and the SoC peripherals (rom, print, clint, bram, and later additions). It decodes each request against per-slot address windows, strobes exactly one slave, and tracks the outstanding transaction so that only the addressed slave's response is returned. Unmapped addresses and unresponsive slaves get an explicit error response instead of a hang.

## Interface
- `SLAVES`, default 4: number of slave slots (1..16).
- `TIMEOUT`, default 255: maximum cycles to wait for `slave_ready` after the request; 0 disables the timeout.
- `BASE_ADDR`, default {32'h0200_0000, 32'h0100_0000, 32'h0010_0000, 32'h0000_0000}: `SLAVES`×32 packed; slot i occupies bits [32i+31:32i].
- `TOP_ADDR`, default {32'h0201_0000, 32'h0100_1000, 32'h0020_0000, 32'h0000_1000}: `SLAVES`×32 packed; exclusive upper bound per slot.

- `clock`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `memory_valid`  in  1  one-cycle request strobe from the arbiter.
- `memory_instr`  in  1  instruction-fetch qualifier; forwarded unchanged.
- `memory_addr`  in  32  byte address.
- `memory_wdata`  in  32  write data.
- `memory_wstrb`  in  4  byte write strobes; 0 means read.
- `memory_rdata`  out  32  read data, valid while `memory_ready`=1.
- `memory_ready`  out  1  one-cycle completion pulse.
- `memory_error`  out  1  asserted with `memory_ready` on decode error or timeout.
- `slave_valid`  out  SLAVES  one-hot request strobe.
- `slave_instr`  out  1  shared copy of `memory_instr`.
- `slave_addr`  out  32  `memory_addr` − `BASE_ADDR[sel]`, shared.
- `slave_wdata`  out  32  shared copy of `memory_wdata`.
- `slave_wstrb`  out  4  shared copy of `memory_wstrb`.
- `slave_rdata`  in  SLAVES×32  per-slot read data.
- `slave_ready`  in  SLAVES  per-slot completion.

## Operation
- Decode (combinational): slot i hits when BASE_ADDR[i] ≤ addr < TOP_ADDR[i], compared unsigned. On overlapping windows the lowest index wins. With no hit the request is unmapped and `slave_addr` = addr.
- States: IDLE, BUSY, ERR. The selected index `sel` is held in a register of width clog2(SLAVES). The timeout counter is clog2(TIMEOUT+1) bits wide.
- IDLE with `memory_valid` and a hit:
  - `slave_valid[sel]`=1 in the same cycle, and `sel` is latched.
  - If `slave_ready[sel]`=1 in that same cycle (zero-wait slave), the transaction completes immediately and the state stays IDLE.
  - Otherwise the state moves to BUSY and the counter is cleared.
- IDLE with `memory_valid` and no hit: move to ERR. No slave is strobed.
- BUSY:
  - `memory_ready` = `slave_ready[sel]` and `memory_rdata` = `slave_rdata[sel]`. On ready, return to IDLE.
  - `slave_ready` from any other slot is ignored.
  - The counter increments each cycle. When it equals TIMEOUT (TIMEOUT≠0) with no ready: `memory_ready`=1, `memory_error`=1, `memory_rdata`=0, then return to IDLE.
  - A late `slave_ready` from the timed-out slot arriving in IDLE is ignored.
- ERR: for one cycle, `memory_ready`=1, `memory_error`=1, `memory_rdata`=0; then IDLE.
- `memory_valid` while in BUSY or ERR is a protocol violation: it is dropped, no slave is strobed, and the state is unaffected.
- Outside completion cycles, `memory_rdata` and `memory_error` are 0.
- Reset (asynchronous, any state, including mid-transaction):
  - State → IDLE; `sel` and the counter → 0.
  - While `reset`=1, all outputs are forced to 0: `slave_valid`, `memory_ready`, `memory_error`, `memory_rdata`.
  - Any outstanding response is discarded.

## Timing
- Decode to `slave_valid`: 0 cycles, combinational from `memory_*`.
- Response to master: 0 added cycles; `memory_ready` is coincident with `slave_ready[sel]`.
- Unmapped address: `memory_ready`+`memory_error` exactly 1 cycle after `memory_valid`.
- Timeout: error response TIMEOUT cycles after the request cycle (request at cycle t, error at t+TIMEOUT).
- Back-to-back: a new `memory_valid` is accepted in the cycle after completion. On a zero-wait slave, a new request is accepted every cycle.
- At most one outstanding transaction at all times.

## Test plan
- Read at 0x0010_0040, bram (slot 1) answers 1 cycle later with 0xDEADBEEF → `slave_valid`=4'b0010, `slave_addr`=0x40, next cycle `memory_ready`=1, `memory_rdata`=0xDEADBEEF, `memory_error`=0.
- Write 0x0000_0001 with `wstrb`=4'hF to 0x0100_0000 (print) → `slave_valid`=4'b0100, `slave_addr`=0, `slave_wstrb`=4'hF. Slot 3 pulses `slave_ready` while slot 2 is pending → pulse ignored. Slot 2 ready later → single `memory_ready`.
- Read at 0x0300_0000 (unmapped) → `slave_valid`=0 throughout; next cycle `memory_ready`=1, `memory_error`=1, `memory_rdata`=0.
- Read to slot 3 with TIMEOUT=8, slave never ready → error completion exactly 8 cycles after the request. A slave ready at +10 produces no `memory_ready`.
- Assert `reset` while BUSY on slot 1, release, then slot 1 pulses ready → no `memory_ready`, all outputs 0 during reset, state IDLE. A following request to slot 0 completes normally.
- Zero-wait slot 0 with requests on 4 consecutive cycles at 0x0, 0x4, 0x8, 0xC → 4 `memory_ready` pulses in the same cycles, `slave_addr` matching each address.
